mealy_state_observer: RTL and testbench

- Passive receive-side observer for the 6-state Mealy machine (inputs `in`, output `out`, states S0..S5).
- Consumes the machine's `(in, out)` stream and tracks the set of states consistent with the observations.
- Declares lock when exactly one state remains, and flags a protocol fault when no state can explain the stream.
- Sits beside the machine or at the far end of its output link, for self-checking and state recovery.

---
 rtl/mealy_pkg.sv | 67 ++++++
 rtl/mealy_cand_step.sv | 23 ++
 rtl/mealy_state_observer.sv | 130 +++++++++++++
 tb/tb_mealy_state_observer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mealy_pkg.sv
// Shared definitions for the 6-state Mealy machine and its observer:
// state encodings, transition/output functions and the observer FSM enum.
package mealy_pkg;

    localparam int NUM_STATES = 6;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } mealy_state_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } obs_state_t;

    function automatic logic mealy_out(input logic [2:0] s, input logic in_bit);
        logic o;
        case (s)
            S0:      o = in_bit;
            S1:      o = 1'b1;
            S2:      o = ~in_bit;
            S3:      o = ~in_bit;
            S4:      o = 1'b1;
            default: o = 1'b0;
        endcase
        return o;
    endfunction

    function automatic logic [2:0] mealy_next(input logic [2:0] s, input logic in_bit);
        logic [2:0] n;
        case (s)
            S0:      n = in_bit ? S2 : S0;
            S1:      n = in_bit ? S4 : S0;
            S2:      n = in_bit ? S1 : S5;
            S3:      n = in_bit ? S2 : S3;
            S4:      n = in_bit ? S4 : S2;
            default: n = in_bit ? S4 : S3;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] popcount6(input logic [NUM_STATES-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Index of the highest set bit; only meaningful for a one-hot input.
    function automatic logic [2:0] onehot_idx(input logic [NUM_STATES-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mealy_cand_step.sv
// Combinational candidate-set update: keep states whose output matches the
// observed sample and advance them to their successors.
module mealy_cand_step
    import mealy_pkg::*;
(
    input  logic [NUM_STATES-1:0] cand,
    input  logic                  smp_in,
    input  logic                  smp_out,
    output logic [NUM_STATES-1:0] new_cand,
    output logic [2:0]            new_cnt
);

    always_comb begin
        new_cand = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (cand[i] && (mealy_out(3'(i), smp_in) == smp_out)) begin
                new_cand[mealy_next(3'(i), smp_in)] = 1'b1;
            end
        end
        new_cnt = popcount6(new_cand);
    end

endmodule

// File: rtl/mealy_state_observer.sv
// Passive observer tracking the states of the Mealy machine consistent with
// its (in, out) stream. Optional counters enabled by MEALY_OBS_STATS_EN.
module mealy_state_observer
    import mealy_pkg::*;
#(
    parameter logic [NUM_STATES-1:0] INIT_SET = 6'h3F,
    parameter int                    CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  resync,
    input  logic                  smp_valid,
    input  logic                  smp_in,
    input  logic                  smp_out,
    output logic [NUM_STATES-1:0] cand,
    output logic                  locked,
    output logic [2:0]            est_state,
    output logic                  fault,
    output logic [CNT_W-1:0]      lock_age,
    output logic [15:0]           sample_cnt,
    output logic [15:0]           fault_cnt
);

    // An empty initial set can never be explained, so it starts in FAULT.
    localparam obs_state_t INIT_STATE =
        (popcount6(INIT_SET) == 3'd0) ? FAULT  :
        (popcount6(INIT_SET) == 3'd1) ? LOCKED : SEARCH;
    localparam logic [2:0] INIT_EST = (INIT_STATE == LOCKED) ? onehot_idx(INIT_SET) : 3'd0;

    obs_state_t            state, state_nxt;
    logic [NUM_STATES-1:0] cand_nxt;
    logic [NUM_STATES-1:0] step_cand;
    logic [2:0]            step_cnt;
    logic [CNT_W-1:0]      age_nxt;
    logic                  locked_nxt;
    logic [2:0]            est_nxt;
    logic                  fault_nxt;
    logic                  fault_entry;
    logic                  accept;

    mealy_cand_step u_step (
        .cand     (cand),
        .smp_in   (smp_in),
        .smp_out  (smp_out),
        .new_cand (step_cand),
        .new_cnt  (step_cnt)
    );

    assign accept = smp_valid && !resync;

    always_comb begin
        state_nxt   = state;
        cand_nxt    = cand;
        age_nxt     = lock_age;
        fault_entry = 1'b0;
        if (resync) begin
            state_nxt = INIT_STATE;
            cand_nxt  = INIT_SET;
            age_nxt   = '0;
        end else if (smp_valid) begin
            case (state)
                SEARCH: begin
                    if (step_cnt == 3'd0) begin
                        state_nxt   = FAULT;
                        cand_nxt    = '0;
                        fault_entry = 1'b1;
                    end else if (step_cnt == 3'd1) begin
                        state_nxt = LOCKED;
                        cand_nxt  = step_cand;
                        age_nxt   = '0;
                    end else begin
                        cand_nxt = step_cand;
                    end
                end
                LOCKED: begin
                    if (step_cnt == 3'd0) begin
                        state_nxt   = FAULT;
                        cand_nxt    = '0;
                        fault_entry = 1'b1;
                    end else begin
                        cand_nxt = step_cand;
                        age_nxt  = (&lock_age) ? lock_age : lock_age + 1'b1;
                    end
                end
                default: begin
                    cand_nxt = '0;
                end
            endcase
        end
        locked_nxt = (state_nxt == LOCKED);
        est_nxt    = locked_nxt ? onehot_idx(cand_nxt) : 3'd0;
        fault_nxt  = (state_nxt == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_STATE;
            cand      <= INIT_SET;
            lock_age  <= '0;
            locked    <= (INIT_STATE == LOCKED);
            est_state <= INIT_EST;
            fault     <= (INIT_STATE == FAULT);
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            lock_age  <= age_nxt;
            locked    <= locked_nxt;
            est_state <= est_nxt;
            fault     <= fault_nxt;
        end
    end

`ifdef MEALY_OBS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            fault_cnt  <= '0;
        end else begin
            if (accept && !(&sample_cnt)) sample_cnt <= sample_cnt + 16'd1;
            if (fault_entry && !(&fault_cnt)) fault_cnt <= fault_cnt + 16'd1;
        end
    end
`else
    assign sample_cnt = 16'd0;
    assign fault_cnt  = 16'd0;
    logic unused_stats;
    assign unused_stats = accept ^ fault_entry;
`endif

endmodule

// File: tb/tb_mealy_state_observer.sv
// Directed testbench for mealy_state_observer with hand-computed expectations.
module tb_mealy_state_observer;

    logic        clk = 1'b0;
    logic        rst, resync, smp_valid, smp_in, smp_out;
    logic [5:0]  cand;
    logic        locked, fault;
    logic [2:0]  est_state;
    logic [7:0]  lock_age;
    logic [15:0] sample_cnt, fault_cnt;

    int checks = 0;
    int failures = 0;
    int exp_sc = 0;
    int exp_fc = 0;

`ifdef MEALY_OBS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    mealy_state_observer dut (
        .clk        (clk),
        .rst        (rst),
        .resync     (resync),
        .smp_valid  (smp_valid),
        .smp_in     (smp_in),
        .smp_out    (smp_out),
        .cand       (cand),
        .locked     (locked),
        .est_state  (est_state),
        .fault      (fault),
        .lock_age   (lock_age),
        .sample_cnt (sample_cnt),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic i, input logic o);
        smp_valid = v;
        smp_in    = i;
        smp_out   = o;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_sample_cnt"}, 32'(sample_cnt), STATS ? 32'(exp_sc) : 32'd0);
        check({tag, "_fault_cnt"},  32'(fault_cnt),  STATS ? 32'(exp_fc) : 32'd0);
    endtask

    logic [5:0] hold_cand;
    logic [7:0] hold_age;
    logic       hold_locked;

    initial begin
        rst = 1'b1; resync = 1'b0; smp_valid = 1'b0; smp_in = 1'b0; smp_out = 1'b0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        rst = 1'b0;
        exp_sc = 0; exp_fc = 0;
        check("rst_cand", 32'(cand), 32'h3F);
        check("rst_locked", 32'(locked), 0);
        check("rst_est", 32'(est_state), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_age", 32'(lock_age), 0);
        check_counters("rst");

        cycle(1, 0, 0); exp_sc++;
        check("s1_cand", 32'(cand), 32'h09);
        check("s1_locked", 32'(locked), 0);
        cycle(1, 1, 1); exp_sc++;
        check("s2_cand", 32'(cand), 32'h04);
        check("s2_locked", 32'(locked), 1);
        check("s2_est", 32'(est_state), 2);
        check("s2_age", 32'(lock_age), 0);
        cycle(1, 0, 1); exp_sc++;
        check("s3_est", 32'(est_state), 5);
        check("s3_age", 32'(lock_age), 1);
        cycle(1, 0, 1); exp_sc++; exp_fc++;
        check("flt_fault", 32'(fault), 1);
        check("flt_cand", 32'(cand), 0);
        check("flt_locked", 32'(locked), 0);
        cycle(1, 1, 0); exp_sc++;
        check("flt_hold_fault", 32'(fault), 1);
        check("flt_hold_cand", 32'(cand), 0);
        check_counters("flt");

        resync = 1'b1;
        cycle(1, 0, 0);
        resync = 1'b0;
        check("rsy_cand", 32'(cand), 32'h3F);
        check("rsy_fault", 32'(fault), 0);
        check("rsy_locked", 32'(locked), 0);
        check_counters("rsy");

        rst = 1'b1;
        cycle(0, 0, 0);
        rst = 1'b0;
        exp_sc = 0; exp_fc = 0;
        cycle(1, 1, 0); exp_sc++;
        check("b1_cand", 32'(cand), 32'h16);
        cycle(1, 1, 1); exp_sc++;
        check("b2_cand", 32'(cand), 32'h10);
        check("b2_locked", 32'(locked), 1);
        check("b2_est", 32'(est_state), 4);
        for (int k = 0; k < 300; k++) begin
            cycle(1, 1, 1); exp_sc++;
            if (k == 9) check("b_age10", 32'(lock_age), 10);
        end
        check("sat_age", 32'(lock_age), 255);
        check("sat_est", 32'(est_state), 4);
        check("sat_locked", 32'(locked), 1);
        check_counters("sat");

        hold_cand = cand; hold_age = lock_age; hold_locked = locked;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 1'($urandom), 1'($urandom));
        end
        check("idle_cand", 32'(cand), 32'h10);
        check("idle_age", 32'(lock_age), 255);
        check("idle_locked", 32'(locked), 1);
        check_counters("idle");

        rst = 1'b1;
        cycle(1, 1, 1);
        rst = 1'b0;
        exp_sc = 0; exp_fc = 0;
        check("mrst_cand", 32'(cand), 32'h3F);
        check("mrst_locked", 32'(locked), 0);
        check("mrst_age", 32'(lock_age), 0);
        check_counters("mrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
